vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the width of every address port.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the CPU request queue depth; power of two, minimum 2.
REQ-003 clk  input  1  SHALL be the single clock (50 MHz system clock); all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 vga_req  input  1  SHALL be a one-clk pulse requesting a frame-buffer read.
REQ-006 vga_addr  input  ADDR_WIDTH  SHALL be the read address, sampled with vga_req.
REQ-007 vga_valid  output  1  SHALL pulse for one clk when vga_data is valid.
REQ-008 vga_data  output  16  SHALL be the returned glyph word, held until the next vga_valid.
REQ-009 cpu_req  input  1  SHALL push one CPU operation when high and cpu_ready is high.
REQ-010 cpu_we  input  1  SHALL select write (1) or read (0).
REQ-011 cpu_addr  input  ADDR_WIDTH  SHALL be the CPU address.
REQ-012 cpu_wdata  input  16  SHALL be the CPU write data.
REQ-013 cpu_ready  output  1  SHALL be high when the queue is not full.
REQ-014 cpu_rvalid  output  1  SHALL pulse for one clk when cpu_rdata is valid.
REQ-015 cpu_rdata  output  16  SHALL be CPU read data, held until the next cpu_rvalid.
REQ-016 mem_addr  output  ADDR_WIDTH  SHALL be the registered single-port RAM address.
REQ-017 mem_we  output  1  SHALL be the registered RAM write enable.
REQ-018 mem_wdata  output  16  SHALL be the registered RAM write data.
REQ-019 mem_rdata  input  16  SHALL be RAM read data, valid one clk after mem_addr is presented.
REQ-020 overrun  output  1  SHALL be a sticky flag for VGA protocol violation.

Function
REQ-021 CPU queue: FIFO of {we, addr, wdata}; a push occurs when cpu_req && cpu_ready; cpu_ready derives from the registered count only.
REQ-022 Arbiter states: IDLE, VGA_RD, CPU_RD, CPU_WR, re-evaluated every clk.
REQ-023 vga_req high -> next state VGA_RD regardless of queue contents (absolute VGA priority); mem_addr <= vga_addr, mem_we <= 0.
REQ-024 vga_req low and queue non-empty -> pop head; head we=1 -> CPU_WR (mem_we <= 1, mem_addr/mem_wdata from head); we=0 -> CPU_RD (mem_we <= 0).
REQ-025 vga_req low and queue empty -> IDLE, mem_we <= 0, mem_addr holds its value.
REQ-026 mem_we SHALL be high exactly one clk per CPU write.
REQ-027 Read return: a 2-bit shadow pipe tags each issued read (VGA/CPU); one clk after VGA_RD/CPU_RD, mem_rdata is captured into vga_data/cpu_rdata and vga_valid/cpu_rvalid pulses on the following clk edge; total latency request -> valid = 2 clks for VGA.
REQ-028 Queue ordering SHALL be strict FIFO; a CPU read issued after a queued write to the same address SHALL return the written data.
REQ-029 Simultaneous push and pop in one clk SHALL leave count unchanged; push while full is ignored (cpu_ready low).
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-031 vga_req high on two consecutive clks SHALL set overrun; both reads are still serviced in order.
REQ-032 A CPU op blocked by vga_req SHALL stay at queue head and issue on the first clk with vga_req low.

Reset
REQ-033 reset low SHALL immediately clear: state IDLE, FIFO pointers/count 0, mem_addr 0, mem_we 0, mem_wdata 0, vga_data 0, cpu_rdata 0, vga_valid 0, cpu_rvalid 0, overrun 0, read pipe tags 0; cpu_ready high one clk after release.
REQ-034 Reads in flight at reset SHALL be discarded, never returned.

Verification
REQ-035 reset release, vga_req pulse with vga_addr=0x3000, mem model returns 0x4142 -> vga_valid at +2 clks, vga_data=0x4142, mem_we never high.
REQ-036 Push 4 writes (addr 0x3000..0x3003, data 0x0001..0x0004) with no vga_req -> cpu_ready low after 4th push, four mem_we pulses in order, cpu_ready high again.
REQ-037 Queued write 0x3005<=0xBEEF then read 0x3005, vga_req asserted on the write's issue clk -> VGA read first, write one clk later, cpu_rdata=0xBEEF.
REQ-038 vga_req every 4th clk for 1000 clks with continuous CPU writes -> every vga_valid exactly 2 clks after its request, no CPU write lost, overrun stays 0.
REQ-039 vga_req high two consecutive clks -> overrun=1 and sticky until reset; two vga_valid pulses in order.
REQ-040 reset asserted while a CPU read is in flight and queue holds 3 ops -> no cpu_rvalid afterwards, count=0, mem_we=0 immediately.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM arbiter: one single-port RAM shared by a VGA reader with absolute
// priority and a queued CPU read/write port. Read data returns two clocks
// after issue, steered back to its requester by a small tag pipe.
module vram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_valid,
    output logic [15:0]           vga_data,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [15:0]           cpu_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic                  overrun
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_W-1:0]     wdata;
    } cpu_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VGA_RD = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } state_t;

    state_t           state;
    cpu_op_t          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       rd_tag;      // {vga read, cpu read} issued one clk earlier
    logic             vga_req_q;

    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] count_next_c;
    cpu_op_t          head_c;

    // Queue handshake; a CPU op only issues when the VGA port is quiet.
    always_comb begin
        push_c       = cpu_req && cpu_ready;
        pop_c        = !vga_req && (count != '0);
        count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
        head_c       = fifo_mem[rd_ptr];
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= {cpu_we, cpu_addr, cpu_wdata};
        end
    end

    // Arbiter FSM, queue pointers, read-return pipe and overrun detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cpu_ready  <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            rd_tag     <= 2'b00;
            vga_valid  <= 1'b0;
            vga_data   <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            vga_req_q  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            count     <= count_next_c;
            cpu_ready <= (count_next_c != CNT_W'(FIFO_DEPTH));
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            mem_we <= 1'b0;
            if (vga_req) begin
                state    <= VGA_RD;
                mem_addr <= vga_addr;
            end else if (count != '0) begin
                mem_addr <= head_c.addr;
                if (head_c.we) begin
                    state     <= CPU_WR;
                    mem_we    <= 1'b1;
                    mem_wdata <= head_c.wdata;
                end else begin
                    state <= CPU_RD;
                end
            end else begin
                state <= IDLE;
            end

            // RAM answers one clk after the address; capture it the clk after.
            rd_tag     <= {state == VGA_RD, state == CPU_RD};
            vga_valid  <= rd_tag[1];
            cpu_rvalid <= rd_tag[0];
            if (rd_tag[1]) begin
                vga_data <= mem_rdata;
            end
            if (rd_tag[0]) begin
                cpu_rdata <= mem_rdata;
            end

            vga_req_q <= vga_req;
            if (vga_req && vga_req_q) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_vram_arbiter;

    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_valid;
    logic [15:0]   vga_data;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [15:0]   cpu_wdata = '0;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [15:0]   cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          overrun;

    vram_arbiter #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_data(vga_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h4142 : (a ^ 16'hA5C3);
    endfunction

    // Single-port RAM: registered read, one clk latency.
    logic [15:0] ram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // ---------------- reference model ----------------
    typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } op_t;
    typedef struct { int cyc; logic [15:0] data; } ev_t;
    typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; } wr_t;

    op_t         op_q[$];
    ev_t         exp_v[$];
    ev_t         exp_c[$];
    wr_t         exp_w[$];
    logic [15:0] ref_mem [int];
    int          cyc = 0;
    bit          ready_m = 0;
    bit          ov_m = 0;
    bit          prev_vga = 0;
    bit          pw_valid = 0;
    logic [15:0] pw_addr = '0;
    logic [15:0] pw_data = '0;
    logic [15:0] last_vd = '0;
    logic [15:0] last_cd = '0;
    int          m_wr_acc = 0;
    int          m_rd_acc = 0;
    int          dut_we_cnt = 0;
    int          dut_cr_cnt = 0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                op_q.delete(); exp_v.delete(); exp_c.delete(); exp_w.delete();
                ready_m = 0; ov_m = 0; prev_vga = 0; pw_valid = 0;
                last_vd = '0; last_cd = '0;
            end else begin
                op_t op;
                cyc++;
                // a write issued last clk lands in RAM on this edge
                if (pw_valid) ref_mem[int'(pw_addr)] = pw_data;
                pw_valid = 0;
                if (vga_req) begin
                    exp_v.push_back('{cyc + 2, ref_rd(vga_addr)});
                end else if (op_q.size() > 0) begin
                    op = op_q.pop_front();
                    if (op.we) begin
                        pw_valid = 1; pw_addr = op.addr; pw_data = op.wdata;
                        exp_w.push_back('{cyc, op.addr, op.wdata});
                    end else begin
                        exp_c.push_back('{cyc + 2, ref_rd(op.addr)});
                    end
                end
                if (cpu_req && ready_m) begin
                    op_q.push_back('{cpu_we, cpu_addr, cpu_wdata});
                    if (cpu_we) m_wr_acc++; else m_rd_acc++;
                end
                ready_m = (op_q.size() < DEPTH);
                if (vga_req && prev_vga) ov_m = 1;
                prev_vga = vga_req;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            bit ev;
            bit ec;
            bit ew;
            @(posedge clk);
            #1;
            if (reset) begin
                ev = (exp_v.size() > 0) && (exp_v[0].cyc == cyc);
                check("m_vga_valid", 32'(vga_valid), 32'(ev));
                if (ev) begin last_vd = exp_v[0].data; exp_v.delete(0); end
                check("m_vga_data", 32'(vga_data), 32'(last_vd));
                ec = (exp_c.size() > 0) && (exp_c[0].cyc == cyc);
                check("m_cpu_rvalid", 32'(cpu_rvalid), 32'(ec));
                if (ec) begin last_cd = exp_c[0].data; exp_c.delete(0); end
                check("m_cpu_rdata", 32'(cpu_rdata), 32'(last_cd));
                ew = (exp_w.size() > 0) && (exp_w[0].cyc == cyc);
                check("m_mem_we", 32'(mem_we), 32'(ew));
                if (ew) begin
                    check("m_mem_addr", 32'(mem_addr), 32'(exp_w[0].addr));
                    check("m_mem_wdata", 32'(mem_wdata), 32'(exp_w[0].data));
                    exp_w.delete(0);
                end
                check("m_cpu_ready", 32'(cpu_ready), 32'(ready_m));
                check("m_overrun", 32'(overrun), 32'(ov_m));
                if (mem_we) dut_we_cnt++;
                if (cpu_rvalid) dut_cr_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        vreq; logic [15:0] vaddr;
        logic        creq; logic cwe; logic [15:0] caddr; logic [15:0] cwdata;
        logic        e_vv; logic [15:0] e_vd;
        logic        e_cv; logic [15:0] e_cd;
        logic        e_we; logic [15:0] e_ma;
        logic        e_rdy; logic e_ov;
    } vec_t;

    vec_t tbl [11];

    task automatic drive(input logic vr, input logic [15:0] va, input logic cr,
                         input logic cw, input logic [15:0] ca, input logic [15:0] cd);
        vga_req = vr; vga_addr = va; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    endtask

    initial begin
        int rv;
        int wv;
        // read 0x3000, then write 0x3005<=BEEF blocked by a VGA read, then read it back
        tbl[0]  = '{1'b1, 16'h3000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h3000, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h3000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h4142, 1'b0, 16'h0000, 1'b0, 16'h3000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h4142, 1'b0, 16'h0000, 1'b0, 16'h3000, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h3005, 16'hBEEF, 1'b0, 16'h4142, 1'b0, 16'h0000, 1'b0, 16'h3000, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 16'h3001, 1'b1, 1'b0, 16'h3005, 16'h0000, 1'b0, 16'h4142, 1'b0, 16'h0000, 1'b0, 16'h3001, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h4142, 1'b0, 16'h0000, 1'b1, 16'h3005, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h95C2, 1'b0, 16'h0000, 1'b0, 16'h3005, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h95C2, 1'b0, 16'h0000, 1'b0, 16'h3005, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h95C2, 1'b1, 16'hBEEF, 1'b0, 16'h3005, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h95C2, 1'b0, 16'hBEEF, 1'b0, 16'h3005, 1'b1, 1'b0};

        // reset values
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_vga_valid", 32'(vga_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk) reset = 1'b1;
        #1 check("rel_cpu_ready_low", 32'(cpu_ready), 32'd0);
        @(posedge clk) #1 check("rel_cpu_ready_high", 32'(cpu_ready), 32'd1);

        // directed vector table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tbl[i].vreq, tbl[i].vaddr, tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwdata);
            @(posedge clk);
            #1;
            check($sformatf("t%0d_vga_valid", i), 32'(vga_valid), 32'(tbl[i].e_vv));
            check($sformatf("t%0d_vga_data", i), 32'(vga_data), 32'(tbl[i].e_vd));
            check($sformatf("t%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(tbl[i].e_cv));
            check($sformatf("t%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(tbl[i].e_cd));
            check($sformatf("t%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].e_we));
            check($sformatf("t%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_ma));
            check($sformatf("t%0d_cpu_ready", i), 32'(cpu_ready), 32'(tbl[i].e_rdy));
            check($sformatf("t%0d_overrun", i), 32'(overrun), 32'(tbl[i].e_ov));
        end

        // fill the queue behind back-to-back VGA reads (sets overrun), 5th push refused
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b1, 16'(16'h0100 + k), 1'b1, (k != 0),
                  (k == 0) ? 16'h3005 : 16'(16'h3010 + k - 1), 16'(16'h1111 * k));
            @(posedge clk);
            #1;
            check($sformatf("fill%0d_cpu_ready", k), 32'(cpu_ready), 32'(k < 3));
            check($sformatf("fill%0d_overrun", k), 32'(overrun), 32'(k >= 1));
        end
        @(negedge clk) drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h3013, 16'h4444);
        @(posedge clk) #1;
        check("drain_rd_cpu_ready", 32'(cpu_ready), 32'd1);
        check("drain_rd_mem_we", 32'(mem_we), 32'd0);
        check("drain_rd_mem_addr", 32'(mem_addr), 32'h3005);
        @(negedge clk) drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h3013, 16'h4444);
        @(posedge clk) #1;
        check("drain_wr_mem_we", 32'(mem_we), 32'd1);
        check("drain_wr_mem_addr", 32'(mem_addr), 32'h3010);
        check("drain_wr_mem_wdata", 32'(mem_wdata), 32'h1111);
        check("sticky_overrun", 32'(overrun), 32'd1);

        // reset with a CPU read in flight and three ops queued
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        reset = 1'b0;
        #1;
        check("ir_mem_we", 32'(mem_we), 32'd0);
        check("ir_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("ir_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("ir_vga_data", 32'(vga_data), 32'd0);
        check("ir_overrun", 32'(overrun), 32'd0);
        check("ir_cpu_ready", 32'(cpu_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rv = 0;
        wv = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk) #1;
            if (cpu_rvalid) rv++;
            if (mem_we) wv++;
        end
        check("ir_no_rvalid", 32'(rv), 32'd0);
        check("ir_no_mem_we", 32'(wv), 32'd0);
        check("ir_ready_after", 32'(cpu_ready), 32'd1);

        // VGA every 4th clk with continuous CPU writes
        @(negedge clk);
        m_wr_acc = 0; dut_we_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            drive((i % 4 == 0), 16'(16'h0200 + i), 1'b1, 1'b1,
                  16'(16'h3100 + $urandom_range(0, 255)), 16'($urandom));
            @(negedge clk);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (20) @(negedge clk);
        check("p38_overrun", 32'(overrun), 32'd0);
        check("p38_writes", 32'(dut_we_cnt), 32'(m_wr_acc));

        // random mixed traffic over a small address window
        m_wr_acc = 0; m_rd_acc = 0; dut_we_cnt = 0; dut_cr_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'(16'h3200 + $urandom_range(0, 7)), 16'($urandom));
            @(negedge clk);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (20) @(negedge clk);
        check("rnd_writes", 32'(dut_we_cnt), 32'(m_wr_acc));
        check("rnd_reads", 32'(dut_cr_cnt), 32'(m_rd_acc));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
